// File: rtl/npu_cmp_pkg.sv
// Shared definitions for the popcount controller and its 5-to-3 compressor:
// FSM encoding, compressor widths and sizing helpers.
package npu_cmp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned COMP_IN_W  = 5;
  localparam int unsigned COMP_OUT_W = 3;

  // Compressor passes needed to cover an n-bit vector.
  function automatic int unsigned chunks(input int unsigned n);
    return (n + COMP_IN_W - 1) / COMP_IN_W;
  endfunction

  // Width able to hold a count of 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_5to3.sv
// 5-to-3 compressor: counts the ones among five inputs, result {cout, carry, sum}.
module adder_5to3
  import npu_cmp_pkg::*;
(
  input  logic [COMP_IN_W-1:0] a,
  output logic                 sum,
  output logic                 carry,
  output logic                 cout
);

  logic [COMP_OUT_W-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(COMP_IN_W); i++) begin
      cnt = cnt + COMP_OUT_W'(a[i]);
    end
    {cout, carry, sum} = cnt;
  end

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Sequential popcount: one shared 5-to-3 compressor swept over 5-bit chunks of the vector.
// Define POPCOUNT_THRESH_EN to add the thresh input and the registered out_act activation.
module popcount_seq_ctrl
  import npu_cmp_pkg::*;
#(
  parameter int unsigned  N_BITS = 25,
  localparam int unsigned CNT_W  = cnt_w(N_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_vec,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
`ifdef POPCOUNT_THRESH_EN
  ,
  input  logic [CNT_W-1:0]  thresh,
  output logic              out_act
`endif
);

  localparam int unsigned CHUNKS = chunks(N_BITS);
  localparam int unsigned SH_W   = CHUNKS * COMP_IN_W;
  localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_e            state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  logic                  p_sum, p_carry, p_cout;
  logic [COMP_OUT_W-1:0] partial;
  logic [CNT_W-1:0]      sum_next;
  logic                  last_pass;

  adder_5to3 u_comp (
    .a     (shreg_q[COMP_IN_W-1:0]),
    .sum   (p_sum),
    .carry (p_carry),
    .cout  (p_cout)
  );

  // Truncation of the partial is safe: the running total never exceeds N_BITS.
  assign partial   = {p_cout, p_carry, p_sum};
  assign sum_next  = acc_q + CNT_W'(partial);
  assign last_pass = (state_q == StRun) && (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !abort) begin
          shreg_d = SH_W'(in_vec);
          acc_d   = '0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          acc_d   = sum_next;
          shreg_d = shreg_q >> COMP_IN_W;
          idx_d   = idx_q + 1'b1;
          if (last_pass) begin
            out_count_d = sum_next;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        if (abort) begin
          acc_d       = '0;
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
    end
  end

`ifdef POPCOUNT_THRESH_EN
  logic act_q;

  // Cleared whenever out_valid drops so it is only ever high alongside a valid result.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      act_q <= 1'b0;
    end else if (last_pass) begin
      act_q <= (sum_next >= thresh);
    end else if (state_q == StDone && out_ready) begin
      act_q <= 1'b0;
    end
  end

  assign out_act = act_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Self-checking bench for popcount_seq_ctrl: vector table, random vectors against a
// countones model, and hand sequences for backpressure, abort and reset.
module tb_popcount_seq_ctrl;

  localparam int unsigned NB  = 25;
  localparam int unsigned CW  = 5;
  localparam int unsigned NB7 = 7;
  localparam int unsigned CW7 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, abort;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [NB-1:0] in_vec;
  logic [CW-1:0] out_count;

  logic           in_valid7, in_ready7, out_valid7, busy7;
  logic [NB7-1:0] in_vec7;
  logic [CW7-1:0] out_count7;
  logic           out_ready7 = 1'b1;
  logic           abort7 = 1'b0;

`ifdef POPCOUNT_THRESH_EN
  logic [CW-1:0]  thresh = 5'd13;
  logic           out_act;
  logic [CW7-1:0] thresh7 = 3'd4;
  logic           out_act7;
`endif

  popcount_seq_ctrl #(.N_BITS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
`ifdef POPCOUNT_THRESH_EN
    ,
    .thresh    (thresh),
    .out_act   (out_act)
`endif
  );

  popcount_seq_ctrl #(.N_BITS(NB7)) dut7 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid7),
    .in_ready  (in_ready7),
    .in_vec    (in_vec7),
    .abort     (abort7),
    .out_valid (out_valid7),
    .out_ready (out_ready7),
    .out_count (out_count7),
    .busy      (busy7)
`ifdef POPCOUNT_THRESH_EN
    ,
    .thresh    (thresh7),
    .out_act   (out_act7)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [NB-1:0] vec;
    int            exp_cnt;
    int            hold;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector, check latency and result, hold DONE for `hold` cycles, then drain.
  task automatic send(input logic [NB-1:0] v, input int hold, input int exp_cnt);
    int lat;
    lat = 0;
    chk("in_ready_idle", int'(in_ready), 1);
    in_vec   = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_vec   = NB'($urandom);
    chk("busy_after_accept", int'(busy), 1);
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 5);
    chk("count", int'(out_count), exp_cnt);
`ifdef POPCOUNT_THRESH_EN
    chk("act", int'(out_act), int'(exp_cnt >= int'(thresh)));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_vec   = NB'($urandom);
      step();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_count", int'(out_count), exp_cnt);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_dropped", int'(out_valid), 0);
    chk("in_ready_after", int'(in_ready), 1);
  endtask

  task automatic send7(input logic [NB7-1:0] v);
    int lat;
    lat = 0;
    in_vec7   = v;
    in_valid7 = 1'b1;
    step();
    in_valid7 = 1'b0;
    while (!out_valid7 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency7", lat, 2);
    chk("count7", int'(out_count7), $countones(v));
    step();
    chk("in_ready7_after", int'(in_ready7), 1);
  endtask

  // Counts out_valid pulses over n cycles; used where no result may appear.
  task automatic watch_quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    logic [NB-1:0] rv;
    int            lat;

    tbl[0] = '{25'h1FFFFFF, 25, 0};
    tbl[1] = '{25'h1555555, 13, 0};
    tbl[2] = '{25'h0000000, 0,  0};
    tbl[3] = '{25'h0000FFF, 12, 3};
    tbl[4] = '{25'h1000001, 2,  1};
    tbl[5] = '{25'h0AAAAAA, 12, 2};
    tbl[6] = '{25'h01F001F, 10, 0};

    rst_n = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    in_valid7 = 1'b0; in_vec7 = '0;
    step();
    step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_count", int'(out_count), 0);
`ifdef POPCOUNT_THRESH_EN
    chk("rst_out_act", int'(out_act), 0);
`endif
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", int'(in_ready), 1);

    foreach (tbl[i]) send(tbl[i].vec, tbl[i].hold, tbl[i].exp_cnt);

    send7(7'h7F);
    send7(7'h00);
    send7(7'h41);
    for (int i = 0; i < 4; i++) send7(NB7'($urandom));

    for (int i = 0; i < 40; i++) begin
      rv = NB'($urandom);
      if (i % 4 == 0) rv = rv | NB'($urandom);
      send(rv, int'($urandom_range(0, 3)), $countones(rv));
    end

    // Abort during the second RUN cycle.
    in_vec = '1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_run_busy", int'(busy), 0);
    chk("abort_run_in_ready", int'(in_ready), 1);
    chk("abort_run_valid", int'(out_valid), 0);
    watch_quiet("abort_run_quiet", 6);
    send(25'h1555555, 0, 13);

    // Abort in IDLE blocks that cycle's accept.
    in_vec = '1; in_valid = 1'b1; abort = 1'b1;
    step();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_busy", int'(busy), 0);
    watch_quiet("abort_idle_quiet", 6);

    // Abort in DONE wins over out_ready.
    in_vec = 25'h00000FF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("abort_done_reached", int'(out_valid), 1);
    abort = 1'b1; out_ready = 1'b1;
    step();
    abort = 1'b0; out_ready = 1'b0;
    chk("abort_done_valid", int'(out_valid), 0);
    chk("abort_done_busy", int'(busy), 0);
`ifdef POPCOUNT_THRESH_EN
    chk("abort_done_act", int'(out_act), 0);
`endif
    send(25'h0001FFF, 1, 13);
    send(25'h0000FFF, 0, 12);

    // Synchronous reset in the middle of RUN.
    in_vec = '1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_run_valid", int'(out_valid), 0);
    chk("rst_run_busy", int'(busy), 0);
    chk("rst_run_count", int'(out_count), 0);
    rst_n = 1'b1;
    chk("rst_run_in_ready", int'(in_ready), 1);
    watch_quiet("rst_run_quiet", 6);
    send(25'h1FFFFFF, 0, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
